// File: rtl/avmm_cmd_master_if.sv
// avmm_cmd_master_if
//   Bundles the command stream, the read-response stream and the Avalon-MM
//   initiator signals of avmm_cmd_master.
//
//   Command port  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_data
//   Response port : rsp_valid, rsp_ready, rsp_data
//   Avalon-MM bus : avm_address, avm_chipselect, avm_write_n, avm_read_n,
//                   avm_writedata, avm_readdata, avm_waitrequest
//
//   modport master : the view used by avmm_cmd_master itself
//   modport slave  : the view used by the command source / bus slave side
//
//   ADDR_W and DATA_W must match the parameters of the avmm_cmd_master
//   instance this interface is connected to.
interface avmm_cmd_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/avmm_cmd_master.sv
// avmm_cmd_master
//   Avalon-MM initiator that executes a stream of single-beat register
//   commands (write or read) queued in a small command FIFO. Read results
//   are returned on a valid/ready response port.
//
//   Ports:
//     clk      - system clock
//     reset_n  - asynchronous active-low reset; flushes the FIFO, drops any
//                pending response and deasserts the bus strobes at once
//     bus      - avmm_cmd_master_if.master: command port, response port and
//                Avalon-MM initiator signals (all bus outputs are registered)
//     busy     - FIFO non-empty or a transaction/response still in flight
//
//   Parameters:
//     ADDR_W     - Avalon word-address width
//     DATA_W     - command/bus data width
//     FIFO_DEPTH - command FIFO entries (power of two, >= 2)
module avmm_cmd_master #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    avmm_cmd_master_if.master bus,
    output logic              busy
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Command storage; holds data only, so it needs no reset.
    logic              fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    logic              chipselect_nxt;
    logic              write_n_nxt;
    logic              read_n_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [DATA_W-1:0] writedata_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;

    assign bus.cmd_ready = (count != DEPTH_C);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= bus.cmd_write;
            fifo_addr[wr_ptr]  <= bus.cmd_addr;
            fifo_data[wr_ptr]  <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE pops straight into the bus registers, so the access is visible one
    // cycle after the pop. Only the registered count is looked at, which is
    // why a freshly pushed command cannot be popped in its push cycle.
    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        chipselect_nxt = 1'b0;
        write_n_nxt    = 1'b1;
        read_n_nxt     = 1'b1;
        address_nxt    = bus.avm_address;
        writedata_nxt  = bus.avm_writedata;
        rsp_data_nxt   = bus.rsp_data;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop            = 1'b1;
                    chipselect_nxt = 1'b1;
                    write_n_nxt    = !fifo_write[rd_ptr];
                    read_n_nxt     = fifo_write[rd_ptr];
                    address_nxt    = fifo_addr[rd_ptr];
                    if (fifo_write[rd_ptr]) begin
                        writedata_nxt = fifo_data[rd_ptr];
                    end
                    state_nxt      = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.avm_waitrequest) begin
                    // Stalled: keep every bus output exactly as it is.
                    chipselect_nxt = 1'b1;
                    write_n_nxt    = bus.avm_write_n;
                    read_n_nxt     = bus.avm_read_n;
                end else if (!bus.avm_read_n) begin
                    rsp_data_nxt = bus.avm_readdata;
                    state_nxt    = RESP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_read_n     <= 1'b1;
            bus.avm_address    <= '0;
            bus.avm_writedata  <= '0;
            bus.rsp_data       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            bus.avm_chipselect <= chipselect_nxt;
            bus.avm_write_n    <= write_n_nxt;
            bus.avm_read_n     <= read_n_nxt;
            bus.avm_address    <= address_nxt;
            bus.avm_writedata  <= writedata_nxt;
            bus.rsp_data       <= rsp_data_nxt;
        end
    end
endmodule

// File: tb/tb_avmm_cmd_master.sv
// tb_avmm_cmd_master
//   Bench for avmm_cmd_master: a register-file slave with programmable
//   waitrequest and a 4-bit gain register at address 0, a table of single
//   commands with expected bus/response behaviour, hand-written sequences for
//   FIFO-full, response back-pressure and mid-access reset, and a randomized
//   run checked against an in-order command/memory reference model.
module tb_avmm_cmd_master;
    logic clk;
    logic reset_n;
    logic busy;

    avmm_cmd_master_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    avmm_cmd_master #(.ADDR_W(4), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] slave_mem [16] = '{default: '0};
    logic [3:0]  gain_q         = 4'h0;
    int          wait_used      = 0;
    int          wait_base      = 0;
    int          wait_load      = 0;
    logic        hold_wait      = 1'b0;
    logic        rand_mode      = 1'b0;
    logic        rnd_w          = 1'b0;
    logic        rnd_r          = 1'b0;
    logic        rsp_ready_drv  = 1'b0;
    logic        tbl_wait;

    assign tbl_wait            = (wait_used - wait_base) < wait_load;
    assign bus.avm_waitrequest = bus.avm_chipselect && (hold_wait || tbl_wait || (rand_mode && rnd_w));
    assign bus.avm_readdata    = slave_mem[bus.avm_address];
    assign bus.rsp_ready       = rand_mode ? rnd_r : rsp_ready_drv;

    always @(posedge clk) begin
        if (bus.avm_chipselect && tbl_wait) wait_used <= wait_used + 1;
        rnd_w <= ($urandom_range(0, 3) == 0);
        rnd_r <= ($urandom_range(0, 2) != 0);
        if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest) begin
            slave_mem[bus.avm_address] <= bus.avm_writedata;
            if (bus.avm_address == 4'd0) gain_q <= bus.avm_writedata[3:0];
        end
    end

    // ---------------- reference model / monitor ----------------
    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } cmd_t;

    cmd_t        exp_cmd [$];
    logic [31:0] exp_rsp [$];
    logic [31:0] model_mem [16] = '{default: '0};
    logic        stall_prev = 1'b0;
    logic [38:0] stall_snap = '0;

    always @(negedge clk) begin
        cmd_t        e;
        logic [38:0] cur;
        if (!reset_n) begin
            exp_cmd.delete();
            exp_rsp.delete();
            stall_prev = 1'b0;
        end else begin
            cur = {bus.avm_chipselect, bus.avm_write_n, bus.avm_read_n, bus.avm_address, bus.avm_writedata};
            if (bus.avm_chipselect) chk("strobe_onehot", 64'(bus.avm_write_n ^ bus.avm_read_n), 64'(1));
            else chk("strobe_idle", 64'({bus.avm_write_n, bus.avm_read_n}), 64'(2'b11));
            if (stall_prev) chk("stall_hold", 64'(cur), 64'(stall_snap));
            stall_prev = bus.avm_chipselect && bus.avm_waitrequest;
            stall_snap = cur;
            if (bus.cmd_valid && bus.cmd_ready)
                exp_cmd.push_back('{bus.cmd_write, bus.cmd_addr, bus.cmd_data});
            if (bus.avm_chipselect && !bus.avm_waitrequest) begin
                chk("access_expected", 64'(exp_cmd.size() != 0), 64'(1));
                if (exp_cmd.size() != 0) begin
                    e = exp_cmd.pop_front();
                    chk("acc_kind", 64'(!bus.avm_write_n), 64'(e.w));
                    chk("acc_addr", 64'(bus.avm_address), 64'(e.a));
                    if (e.w) begin
                        chk("acc_wdata", 64'(bus.avm_writedata), 64'(e.d));
                        model_mem[e.a] = e.d;
                    end else begin
                        exp_rsp.push_back(model_mem[e.a]);
                    end
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
                if (exp_rsp.size() != 0) chk("rsp_model", 64'(bus.rsp_data), 64'(exp_rsp.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d, output logic ok);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_rsp_ready();
        @(posedge clk); #1;
        rsp_ready_drv = 1'b1;
        @(posedge clk); #1;
        rsp_ready_drv = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = !busy;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        int          waits;
        int          exp_cs;
        int          exp_lat;
        logic [31:0] exp_rsp;
        logic [3:0]  exp_gain;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic        ok;
        logic        done;
        int          cs_cnt;
        int          lat;
        logic        rw;
        logic [3:0]  ra;
        logic [31:0] rd;

        tbl[0] = '{1'b1, 4'd0,  32'h0000000A, 0, 1, 3, 32'h0,        4'hA};
        tbl[1] = '{1'b0, 4'd0,  32'h0,        0, 1, 3, 32'h0000000A, 4'hA};
        tbl[2] = '{1'b1, 4'd3,  32'h12345678, 3, 4, 6, 32'h0,        4'hA};
        tbl[3] = '{1'b0, 4'd3,  32'h0,        1, 2, 4, 32'h12345678, 4'hA};
        tbl[4] = '{1'b1, 4'd15, 32'hFFFFFFFF, 0, 1, 3, 32'h0,        4'hA};
        tbl[5] = '{1'b0, 4'd15, 32'h0,        2, 3, 5, 32'hFFFFFFFF, 4'hA};
        tbl[6] = '{1'b0, 4'd7,  32'h0,        0, 1, 3, 32'h00000000, 4'hA};
        tbl[7] = '{1'b1, 4'd0,  32'h00000005, 0, 1, 3, 32'h0,        4'h5};
        tbl[8] = '{1'b0, 4'd0,  32'h0,        0, 1, 3, 32'h00000005, 4'h5};

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready",  64'(bus.cmd_ready),      64'(1));
        chk("rst_rsp_valid",  64'(bus.rsp_valid),      64'(0));
        chk("rst_rsp_data",   64'(bus.rsp_data),       64'(0));
        chk("rst_busy",       64'(busy),               64'(0));
        chk("rst_chipselect", 64'(bus.avm_chipselect), 64'(0));
        chk("rst_write_n",    64'(bus.avm_write_n),    64'(1));
        chk("rst_read_n",     64'(bus.avm_read_n),     64'(1));
        chk("rst_address",    64'(bus.avm_address),    64'(0));
        chk("rst_writedata",  64'(bus.avm_writedata),  64'(0));
        reset_n = 1'b1;

        // Table of single commands
        for (int i = 0; i < 9; i++) begin
            wait_base = wait_used;
            wait_load = tbl[i].waits;
            send(tbl[i].w, tbl[i].a, tbl[i].d, ok);
            chk("tbl_accept", 64'(ok), 64'(1));
            cs_cnt = 0;
            lat    = 0;
            done   = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                lat++;
                if (bus.avm_chipselect) cs_cnt++;
                done = tbl[i].w ? !busy : bus.rsp_valid;
            end
            chk("tbl_done",      64'(done),   64'(1));
            chk("tbl_cs_cycles", 64'(cs_cnt), 64'(tbl[i].exp_cs));
            chk("tbl_latency",   64'(lat),    64'(tbl[i].exp_lat));
            if (tbl[i].w) begin
                chk("tbl_gain", 64'(gain_q), 64'(tbl[i].exp_gain));
            end else begin
                chk("tbl_rsp_data", 64'(bus.rsp_data), 64'(tbl[i].exp_rsp));
                repeat (2) begin
                    @(negedge clk);
                    chk("tbl_rsp_hold_valid", 64'(bus.rsp_valid), 64'(1));
                    chk("tbl_rsp_hold_data",  64'(bus.rsp_data),  64'(tbl[i].exp_rsp));
                end
                pulse_rsp_ready();
                @(negedge clk);
                chk("tbl_rsp_cleared", 64'(bus.rsp_valid), 64'(0));
                chk("tbl_busy_after",  64'(busy),          64'(0));
            end
        end
        wait_load = 0;

        // FIFO full: one access stalled plus four queued, sixth refused
        hold_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 4'(8 + i), 32'hC0DE0000 | 32'(i * 32'h1111), ok);
            chk("full_accept", 64'(ok), 64'(1));
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'd2;
        bus.cmd_data  = 32'hBADBAD00;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready_low", 64'(bus.cmd_ready),      64'(0));
            chk("full_cs_held",   64'(bus.avm_chipselect), 64'(1));
            chk("full_addr_held", 64'(bus.avm_address),    64'(8));
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        hold_wait     = 1'b0;
        wait_idle("full_drain", 60);
        for (int i = 0; i < 5; i++)
            chk("full_mem", 64'(slave_mem[8 + i]), 64'(32'hC0DE0000 | 32'(i * 32'h1111)));
        chk("full_no_sixth", 64'(slave_mem[2]), 64'(0));

        // Read then write, response held off for 5 cycles
        send(1'b0, 4'd3, 32'h0, ok);
        chk("bp_accept_rd", 64'(ok), 64'(1));
        send(1'b1, 4'd5, 32'h55AA55AA, ok);
        chk("bp_accept_wr", 64'(ok), 64'(1));
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = bus.rsp_valid;
        end
        chk("bp_rsp_seen", 64'(done),         64'(1));
        chk("bp_rsp_data", 64'(bus.rsp_data), 64'(32'h12345678));
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_issue",  64'(bus.avm_chipselect), 64'(0));
            chk("bp_rsp_valid", 64'(bus.rsp_valid),      64'(1));
        end
        pulse_rsp_ready();
        @(negedge clk);
        chk("bp_idle_gap", 64'(bus.avm_chipselect), 64'(0));
        @(negedge clk);
        chk("bp_wr_cs",   64'(bus.avm_chipselect), 64'(1));
        chk("bp_wr_n",    64'(bus.avm_write_n),    64'(0));
        chk("bp_wr_addr", 64'(bus.avm_address),    64'(5));
        chk("bp_wr_data", 64'(bus.avm_writedata),  64'(32'h55AA55AA));
        wait_idle("bp_drain", 20);

        // Reset during a stalled access with two entries queued
        hold_wait = 1'b1;
        send(1'b1, 4'd6,  32'hDEAD0006, ok);
        send(1'b1, 4'd13, 32'hDEAD000D, ok);
        send(1'b1, 4'd14, 32'hDEAD000E, ok);
        @(negedge clk);
        chk("rr_cs_before", 64'(bus.avm_chipselect), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("rr_async_cs",      64'(bus.avm_chipselect), 64'(0));
        chk("rr_async_write_n", 64'(bus.avm_write_n),    64'(1));
        chk("rr_async_read_n",  64'(bus.avm_read_n),     64'(1));
        repeat (2) @(posedge clk);
        #2 hold_wait = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("rr_cmd_ready", 64'(bus.cmd_ready),      64'(1));
            chk("rr_busy",      64'(busy),               64'(0));
            chk("rr_no_bus",    64'(bus.avm_chipselect), 64'(0));
            chk("rr_rsp_valid", 64'(bus.rsp_valid),      64'(0));
        end
        chk("rr_address", 64'(bus.avm_address), 64'(0));
        chk("rr_mem6",    64'(slave_mem[6]),    64'(0));
        chk("rr_mem13",   64'(slave_mem[13]),   64'(0));
        chk("rr_mem14",   64'(slave_mem[14]),   64'(0));

        // Randomized traffic with random waitrequest and rsp_ready
        wait_base = wait_used;
        wait_load = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rd = $urandom();
            send(rw, ra, rd, ok);
            chk("rand_accept", 64'(ok), 64'(1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = !busy && (exp_cmd.size() == 0) && (exp_rsp.size() == 0);
        end
        chk("rand_drain_cmds", 64'(exp_cmd.size()), 64'(0));
        chk("rand_drain_rsps", 64'(exp_rsp.size()), 64'(0));
        chk("rand_drain_busy", 64'(busy),           64'(0));
        rand_mode = 1'b0;
        for (int i = 0; i < 16; i++)
            chk("rand_mem", 64'(slave_mem[i]), 64'(model_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
